// File: rtl/uart_alu_interface.sv
// Command sequencer between a UART receiver and transmitter: gathers operand A,
// operand B and opcode, presents them to an external ALU and transmits the result.
module uart_alu_interface #(
    parameter int NBIT_DATA = 8,
    parameter int NBIT_OP   = 6
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [NBIT_DATA-1:0] rx_data,
    input  logic                 tx_done_tick,
    input  logic [NBIT_DATA-1:0] alu_result,
    output logic [NBIT_DATA-1:0] alu_a,
    output logic [NBIT_DATA-1:0] alu_b,
    output logic [NBIT_OP-1:0]   alu_op,
    output logic                 tx_start,
    output logic [NBIT_DATA-1:0] tx_data,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_OPA     = 3'd0,
        S_OPB     = 3'd1,
        S_OP      = 3'd2,
        S_CALC    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t               state_r;
    logic [NBIT_DATA-1:0] alu_a_r;
    logic [NBIT_DATA-1:0] alu_b_r;
    logic [NBIT_OP-1:0]   alu_op_r;
    logic [NBIT_DATA-1:0] tx_data_r;
    logic                 tx_start_r;
    logic                 busy_r;
    logic                 overrun_r;

    // Command FSM; every output is a register updated alongside the state.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r    <= S_OPA;
            alu_a_r    <= {NBIT_DATA{1'b0}};
            alu_b_r    <= {NBIT_DATA{1'b0}};
            alu_op_r   <= {NBIT_OP{1'b0}};
            tx_data_r  <= {NBIT_DATA{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                S_OPA: begin
                    if (rx_done_tick) begin
                        alu_a_r <= rx_data;
                        state_r <= S_OPB;
                    end
                end
                S_OPB: begin
                    if (rx_done_tick) begin
                        alu_b_r <= rx_data;
                        state_r <= S_OP;
                    end
                end
                S_OP: begin
                    if (rx_done_tick) begin
                        alu_op_r <= rx_data[NBIT_OP-1:0];
                        state_r  <= S_CALC;
                        busy_r   <= 1'b1;
                    end
                end
                S_CALC: begin
                    // The ALU has had the whole S_CALC cycle to settle.
                    tx_data_r  <= alu_result;
                    tx_start_r <= 1'b1;
                    state_r    <= S_SEND;
                    if (rx_done_tick) begin
                        overrun_r <= 1'b1;
                    end
                end
                S_SEND: begin
                    state_r <= S_WAIT_TX;
                    if (rx_done_tick) begin
                        overrun_r <= 1'b1;
                    end
                end
                S_WAIT_TX: begin
                    if (tx_done_tick) begin
                        busy_r <= 1'b0;
                        // A byte arriving with the stop bit is the next operand A.
                        if (rx_done_tick) begin
                            alu_a_r <= rx_data;
                            state_r <= S_OPB;
                        end else begin
                            state_r <= S_OPA;
                        end
                    end else if (rx_done_tick) begin
                        overrun_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_OPA;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a    = alu_a_r;
    assign alu_b    = alu_b_r;
    assign alu_op   = alu_op_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign busy     = busy_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface with a small behavioural ALU attached.
module tb_uart_alu_interface;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tx_count = 0;
    int tx_cyc   = 0;
    int op_cyc   = 0;
    logic [7:0] exp_q[$];

    uart_alu_interface #(.NBIT_DATA(8), .NBIT_OP(6)) dut (
        .CLK(CLK), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .tx_done_tick(tx_done_tick), .alu_result(alu_result), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    // External ALU: MIPS-style function codes.
    always_comb begin
        case (alu_op)
            6'h20:   alu_result = alu_a + alu_b;
            6'h22:   alu_result = alu_a - alu_b;
            6'h24:   alu_result = alu_a & alu_b;
            6'h25:   alu_result = alu_a | alu_b;
            6'h26:   alu_result = alu_a ^ alu_b;
            6'h27:   alu_result = ~(alu_a | alu_b);
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: each transmitted byte must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (tx_start === 1'b1) begin
            tx_count = tx_count + 1;
            tx_cyc   = cyc;
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: unexpected tx_start, tx_data=%h, nothing expected", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e)
                    $display("FAIL scoreboard: tx_data=%h expected %h", tx_data, e);
                else
                    n_pass = n_pass + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass = n_pass + 1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        op_cyc       = cyc;
        @(posedge CLK); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic tx_done();
        tx_done_tick = 1'b1;
        @(posedge CLK); #1;
        tx_done_tick = 1'b0;
    endtask

    task automatic wait_tx_start(input string name);
        int start;
        bit seen;
        start = tx_count;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge CLK); #1;
            if (tx_count != start) seen = 1'b1;
        end
        n_checks = n_checks + 1;
        if (!seen) $display("FAIL %s: tx_start not seen, got 0 pulses expected 1", name);
        else n_pass = n_pass + 1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_alu_a", alu_a, 8'h00);
        chk("reset_alu_b", alu_b, 8'h00);
        chk("reset_alu_op", alu_op, 6'h00);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_tx_start", tx_start, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        repeat (1000) @(posedge CLK);
        #1 chk("idle_no_tx_start", tx_count, 0);
    endtask

    task automatic test_add();
        int c0;
        c0 = tx_count;
        rx_byte(8'h05);
        rx_byte(8'h03);
        exp_q.push_back(8'h08);
        rx_byte(8'h20);
        chk("add_busy_calc", busy, 1'b1);
        wait_tx_start("add_tx_start");
        chk("add_latency", tx_cyc - op_cyc, 2);
        chk("add_alu_a", alu_a, 8'h05);
        chk("add_alu_b", alu_b, 8'h03);
        chk("add_alu_op", alu_op, 6'h20);
        repeat (5) @(posedge CLK);
        #1 chk("add_busy_wait", busy, 1'b1);
        chk("add_single_pulse", tx_count - c0, 1);
        tx_done();
        chk("add_busy_done", busy, 1'b0);
        chk("add_tx_data_hold", tx_data, 8'h08);
    endtask

    task automatic test_hold();
        rx_byte(8'h07);
        rx_byte(8'h02);
        exp_q.push_back(8'h05);
        rx_byte(8'hE2);
        chk("hold_tx_data_before_capture", tx_data, 8'h08);
        chk("hold_op_truncated", alu_op, 6'h22);
        wait_tx_start("hold_tx_start");
        chk("hold_new_result", tx_data, 8'h05);
        tx_done();
    endtask

    task automatic test_overrun();
        rx_byte(8'h04);
        rx_byte(8'h04);
        exp_q.push_back(8'h04);
        rx_byte(8'h24);
        wait_tx_start("ovr_and_tx_start");
        chk("ovr_clear_before", overrun, 1'b0);
        rx_byte(8'hAA);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_alu_a_kept", alu_a, 8'h04);
        chk("ovr_busy_kept", busy, 1'b1);
        tx_done();
        rx_byte(8'hF0);
        rx_byte(8'h0F);
        exp_q.push_back(8'hFF);
        rx_byte(8'h25);
        wait_tx_start("ovr_or_tx_start");
        chk("ovr_or_result", tx_data, 8'hFF);
        chk("ovr_sticky", overrun, 1'b1);
        tx_done();
    endtask

    task automatic test_simultaneous();
        do_reset();
        rx_byte(8'h01);
        rx_byte(8'h01);
        exp_q.push_back(8'h02);
        rx_byte(8'h20);
        wait_tx_start("sim_first_tx_start");
        tx_done_tick = 1'b1;
        rx_byte(8'h11);
        tx_done_tick = 1'b0;
        chk("sim_alu_a", alu_a, 8'h11);
        chk("sim_overrun", overrun, 1'b0);
        chk("sim_busy", busy, 1'b0);
        rx_byte(8'h22);
        exp_q.push_back(8'hEF);
        rx_byte(8'h22);
        wait_tx_start("sim_sub_tx_start");
        chk("sim_sub_result", tx_data, 8'hEF);
        tx_done();
    endtask

    task automatic test_reset_mid();
        int c0;
        rx_byte(8'h33);
        rx_byte(8'h44);
        #2 reset = 1'b0;
        #1 chk("mid_alu_a_cleared", alu_a, 8'h00);
        chk("mid_alu_b_cleared", alu_b, 8'h00);
        @(posedge CLK); #1 reset = 1'b1;
        @(posedge CLK); #1;
        c0 = tx_count;
        rx_byte(8'h09);
        rx_byte(8'h06);
        exp_q.push_back(8'h0F);
        rx_byte(8'h26);
        wait_tx_start("mid_tx_start");
        repeat (4) @(posedge CLK);
        #1 chk("mid_single_pulse", tx_count - c0, 1);
        chk("mid_xor_result", tx_data, 8'h0F);
        tx_done();
    endtask

    initial begin
        test_reset();
        test_add();
        test_hold();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        repeat (3) @(posedge CLK);
        #1 chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
